prog_mem: RTL and testbench

Parametrised, writable program memory for the basic CPU. It replaces the fixed instruction table with a loadable word array. Programs are written through a load port while `boot` is low. Once `boot` is high, the CPU reads instructions over a request/acknowledge handshake with a configurable number of wait states. Read data is driven onto the shared tri-state data bus only while `boot` is high.

---
 rtl/prog_mem.sv | 142 ++++++++++++++
 tb/tb_prog_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// Loadable program memory for the basic CPU: a load port fills the array while
// boot is low, and a request/acknowledge read port with wait states serves the CPU.
module prog_mem #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_SIZE   = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot,
  input  logic                 rd_req,
  input  logic [ADDR_SIZE-1:0] addr,
  output logic                 rd_ack,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic                 err
);

  localparam int IDX_W  = ADDR_SIZE - 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 3;
  localparam logic [ADDR_SIZE-1:0] DEPTH_W    = ADDR_SIZE'(DEPTH);
  localparam logic [CNT_W-1:0]     LAST_WAIT  = CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   rd_word_q, rd_word_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   err_q, err_d;

  logic [WORD_SIZE-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]       rd_idx, ld_idx, fetch_idx;
  logic [WORD_SIZE-1:0]   fetch_word;
  logic                   accept, ld_fire, enter_drive;
  logic                   unused_addr_lsb;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_W;
  endfunction

  // Byte addresses: the word index drops the LSB.
  assign rd_idx          = addr[ADDR_SIZE-1:1];
  assign ld_idx          = ld_addr[ADDR_SIZE-1:1];
  assign unused_addr_lsb = ^{addr[0], ld_addr[0]};

  assign accept   = (state_q == S_IDLE) && boot && rd_req;
  assign ld_ready = !boot && (state_q == S_IDLE) && !rst;
  assign ld_fire  = ld_valid && ld_ready;

  // With no wait states the fetch happens on the accept edge, so the index
  // comes straight from the address port rather than the captured copy.
  assign fetch_idx  = (state_q == S_IDLE) ? rd_idx : idx_q;
  assign fetch_word = in_range(fetch_idx) ? mem[fetch_idx[MEM_AW-1:0]] : '0;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rd_word_d   = rd_word_q;
    rd_vld_d    = rd_vld_q;
    err_d       = ld_fire && !in_range(ld_idx);
    enter_drive = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d = rd_idx;
          cnt_d = '0;
          err_d = !in_range(rd_idx);
          if (WAIT_STATES == 0) enter_drive = 1'b1;
          else                  state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_WAIT) enter_drive = 1'b1;
      end
      S_DRIVE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // rd_word is loaded on the edge into DRIVE so data and rd_ack share a cycle.
    if (enter_drive) begin
      state_d   = S_DRIVE;
      rd_word_d = fetch_word;
      rd_vld_d  = 1'b1;
    end

    if (!boot) begin
      state_d  = S_IDLE;
      rd_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_word_q <= '0;
      rd_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_word_q <= rd_word_d;
      rd_vld_q  <= rd_vld_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the array has no reset; a program must survive rst.
  always_ff @(posedge clk) begin
    if (ld_fire && in_range(ld_idx)) begin
      mem[ld_idx[MEM_AW-1:0]] <= ld_data;
    end
  end

  assign rd_ack = (state_q == S_DRIVE) && boot;
  assign err    = err_q;
  assign data   = (boot && rd_vld_q) ? rd_word_q : 'z;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: instance 0 uses defaults (WAIT_STATES=0),
// instance 1 uses DEPTH=8, WAIT_STATES=3.
module tb_prog_mem;

  // Each bus carries a pull-up, so an undriven bus reads as all ones.
  localparam logic [15:0] BUS_Z = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot     [2];
  logic        rd_req   [2];
  logic [7:0]  addr     [2];
  logic        ld_valid [2];
  logic [7:0]  ld_addr  [2];
  logic [15:0] ld_data  [2];
  logic        rd_ack   [2];
  logic        ld_ready [2];
  logic        err      [2];
  wire  [15:0] data0;
  wire  [15:0] data1;

  int n_checks = 0;
  int n_fail   = 0;

  pullup (data0);
  pullup (data1);

  always #5 clk = ~clk;

  prog_mem u_ws0 (
    .clk(clk), .rst(rst), .boot(boot[0]), .rd_req(rd_req[0]), .addr(addr[0]),
    .rd_ack(rd_ack[0]), .data(data0), .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
    .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .err(err[0])
  );

  prog_mem #(.DEPTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .boot(boot[1]), .rd_req(rd_req[1]), .addr(addr[1]),
    .rd_ack(rd_ack[1]), .data(data1), .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
    .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .err(err[1])
  );

  function automatic logic [15:0] bus(input int u);
    return (u == 0) ? data0 : data1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int u, input logic [7:0] a, input logic [15:0] d, output logic e);
    ld_valid[u] = 1'b1;
    ld_addr[u]  = a;
    ld_data[u]  = d;
    tick();
    ld_valid[u] = 1'b0;
    e = err[u];
  endtask

  // Returns the word seen with rd_ack, cycles from accept edge to rd_ack,
  // and err pulses seen meanwhile; ends back in IDLE.
  task automatic do_read(input int u, input logic [7:0] a,
                         output logic [15:0] word, output int lat, output int errs);
    rd_req[u] = 1'b1;
    addr[u]   = a;
    tick();
    rd_req[u] = 1'b0;
    lat  = 1;
    errs = 0;
    while (rd_ack[u] !== 1'b1 && lat < 20) begin
      errs += int'(err[u]);
      tick();
      lat++;
    end
    errs += int'(err[u]);
    word = bus(u);
    tick();
  endtask

  task automatic count_acks(input int u, input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      acks += int'(rd_ack[u]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] word;
    int          lat, errs, acks;
    logic        e;

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      boot[u] = 1'b0; rd_req[u] = 1'b0; addr[u] = '0;
      ld_valid[u] = 1'b0; ld_addr[u] = '0; ld_data[u] = '0;
    end
    tick();
    tick();
    check("ld_ready_in_rst", 32'(ld_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rd_ack", 32'(rd_ack[0]), 32'd0);
    check("rst_err",    32'(err[0]),    32'd0);
    check("rst_bus_z",  32'(data0),     32'(BUS_Z));
    check("rst_ld_ready", 32'(ld_ready[0]), 32'd1);

    // ---- instance 0: WAIT_STATES = 0 ----
    load(0, 8'd0,  16'h1805, e);  check("ld0_err", 32'(e), 32'd0);
    load(0, 8'd18, 16'h8000, e);  check("ld18_err", 32'(e), 32'd0);
    boot[0] = 1'b1;
    #1;
    check("boot_ld_ready", 32'(ld_ready[0]), 32'd0);
    check("boot_bus_z",    32'(data0),       32'(BUS_Z));

    do_read(0, 8'd18, word, lat, errs);
    check("rd18_data", 32'(word), 32'h8000);
    check("rd18_lat",  32'(lat),  32'd1);
    check("rd18_err",  32'(errs), 32'd0);
    do_read(0, 8'd0, word, lat, errs);
    check("rd0_data", 32'(word), 32'h1805);
    check("rd0_lat",  32'(lat),  32'd1);
    check("rd0_hold", 32'(data0), 32'h1805);

    addr[0] = 8'd18;
    tick();
    tick();
    check("addr_change_no_effect", 32'(data0), 32'h1805);

    ld_valid[0] = 1'b1; ld_addr[0] = 8'd0; ld_data[0] = 16'h1234;
    #1;
    check("guard_ld_ready", 32'(ld_ready[0]), 32'd0);
    tick();
    ld_valid[0] = 1'b0;
    do_read(0, 8'd0, word, lat, errs);
    check("guard_no_write", 32'(word), 32'h1805);

    rd_req[0] = 1'b1;
    addr[0]   = 8'd18;
    count_acks(0, 6, acks);
    rd_req[0] = 1'b0;
    check("b2b_acks", 32'(acks), 32'd3);
    check("b2b_data", 32'(data0), 32'h8000);

    boot[0] = 1'b0;
    #1;
    check("boot_low_bus_z", 32'(data0), 32'(BUS_Z));
    rd_req[0] = 1'b1;
    addr[0]   = 8'd0;
    count_acks(0, 3, acks);
    rd_req[0] = 1'b0;
    check("boot_low_no_ack", 32'(acks), 32'd0);
    check("boot_low_bus_still_z", 32'(data0), 32'(BUS_Z));

    load(0, 8'd0, 16'h4321, e);
    boot[0] = 1'b1;
    do_read(0, 8'd0, word, lat, errs);
    check("reload_data", 32'(word), 32'h4321);

    // ---- instance 1: DEPTH = 8, WAIT_STATES = 3 ----
    load(1, 8'd2, 16'h0001, e);
    load(1, 8'd0, 16'h0A0A, e);
    boot[1] = 1'b1;

    rd_req[1] = 1'b1;
    addr[1]   = 8'd2;
    tick();
    lat = 1;
    while (rd_ack[1] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    rd_req[1] = 1'b0;
    check("ws3_lat",  32'(lat),   32'd4);
    check("ws3_data", 32'(data1), 32'h0001);
    count_acks(1, 8, acks);
    check("ws3_extra_req_ignored", 32'(acks), 32'd0);

    do_read(1, 8'd20, word, lat, errs);
    check("oor_rd_data", 32'(word), 32'h0000);
    check("oor_rd_lat",  32'(lat),  32'd4);
    check("oor_rd_err",  32'(errs), 32'd1);

    boot[1] = 1'b0;
    load(1, 8'd16, 16'h5555, e);
    check("oor_ld_err", 32'(e), 32'd1);
    tick();
    check("oor_ld_err_once", 32'(err[1]), 32'd0);
    boot[1] = 1'b1;
    do_read(1, 8'd0, word, lat, errs);
    check("oor_ld_no_write", 32'(word), 32'h0A0A);
    check("oor_ld_rd_err",   32'(errs), 32'd0);

    rd_req[1] = 1'b1;
    addr[1]   = 8'd2;
    tick();
    rd_req[1] = 1'b0;
    tick();
    boot[1] = 1'b0;
    #1;
    check("abort_bus_z", 32'(data1), 32'(BUS_Z));
    count_acks(1, 6, acks);
    check("abort_no_ack", 32'(acks), 32'd0);
    boot[1] = 1'b1;
    #1;
    check("abort_vld_cleared", 32'(data1), 32'(BUS_Z));

    rd_req[1] = 1'b1;
    addr[1]   = 8'd0;
    tick();
    rd_req[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_acks(1, 6, acks);
    check("rst_wait_no_ack", 32'(acks), 32'd0);
    check("rst_wait_bus_z",  32'(data1), 32'(BUS_Z));
    do_read(1, 8'd2, word, lat, errs);
    check("rst_keeps_word2", 32'(word), 32'h0001);
    do_read(1, 8'd0, word, lat, errs);
    check("rst_keeps_word0", 32'(word), 32'h0A0A);
    do_read(0, 8'd18, word, lat, errs);
    check("rst_keeps_ws0", 32'(word), 32'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
